vga_frame_scanner: RTL

Hardware pixel scanner that walks a rectangular region of the VGA active area and drives `pix_x`/`pix_y` into a pixel generator such as `vga_screen_pic`. It samples the returned `rgb` after a parametrised pipeline latency and streams each pixel out over a valid/ready interface. It also accumulates a 32-bit frame signature. It replaces host-side screen dumps with an in-fabric, self-checking frame capture that can run on board or in simulation.

---
 rtl/vga_frame_scanner.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/vga_frame_scanner.sv
// vga_frame_scanner: walks a full-frame or windowed region of the VGA active
// area, drives pix_x/pix_y into a pixel generator, samples rgb_in after
// PIPE_LAT cycles and streams each pixel out over valid/ready while folding
// it into a rotate-xor frame signature.
module vga_frame_scanner #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int X_W      = 10,
    parameter int Y_W      = 9,
    parameter int RGB_W    = 12,
    parameter int PIPE_LAT = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic             mode,
    input  logic [X_W-1:0]   win_x0,
    input  logic [X_W-1:0]   win_x1,
    input  logic [Y_W-1:0]   win_y0,
    input  logic [Y_W-1:0]   win_y1,
    output logic [X_W-1:0]   pix_x,
    output logic [Y_W-1:0]   pix_y,
    input  logic [RGB_W-1:0] rgb_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [X_W-1:0]   out_x,
    output logic [Y_W-1:0]   out_y,
    output logic [RGB_W-1:0] out_rgb,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [31:0]      sig,
    output logic [19:0]      pix_cnt
);

    localparam int               LAT_W    = (PIPE_LAT > 0) ? $clog2(PIPE_LAT + 1) : 1;
    localparam logic [LAT_W-1:0] LAT_LOAD = LAT_W'(PIPE_LAT);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_HOLD,
        S_DONE
    } state_t;

    state_t             r_state;
    logic [LAT_W-1:0]   r_settle;
    logic [X_W-1:0]     r_x0, r_x1, r_pix_x, r_out_x;
    logic [Y_W-1:0]     r_y0, r_y1, r_pix_y, r_out_y;
    logic [RGB_W-1:0]   r_out_rgb;
    logic               r_out_valid, r_busy, r_done, r_err;
    logic [31:0]        r_sig;
    logic [19:0]        r_pix_cnt;

    logic               w_win_bad;
    logic [X_W-1:0]     w_x0, w_x1;
    logic [Y_W-1:0]     w_y0, w_y1;
    logic               w_handshake;
    logic               w_last;
    logic [31:0]        w_sig_next;
    logic [19:0]        w_cnt_next;

    // A window is only validated in mode 1; mode 0 always scans the whole active area.
    assign w_win_bad = mode & ((win_x0 > win_x1) | (win_y0 > win_y1) |
                               (32'(win_x1) >= H_ACTIVE) | (32'(win_y1) >= V_ACTIVE));
    assign w_x0 = mode ? win_x0 : '0;
    assign w_x1 = mode ? win_x1 : X_W'(H_ACTIVE - 1);
    assign w_y0 = mode ? win_y0 : '0;
    assign w_y1 = mode ? win_y1 : Y_W'(V_ACTIVE - 1);

    assign w_handshake = r_out_valid & out_ready;
    assign w_last      = (r_pix_x == r_x1) && (r_pix_y == r_y1);
    assign w_sig_next  = {r_sig[30:0], r_sig[31]} ^ 32'(r_out_rgb);
    assign w_cnt_next  = (&r_pix_cnt) ? r_pix_cnt : r_pix_cnt + 20'd1;

    // Scan FSM: bounds latch, settle countdown, output hold and signature update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_settle    <= '0;
            r_x0        <= '0;
            r_x1        <= '0;
            r_y0        <= '0;
            r_y1        <= '0;
            r_pix_x     <= '0;
            r_pix_y     <= '0;
            r_out_x     <= '0;
            r_out_y     <= '0;
            r_out_rgb   <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_sig       <= '0;
            r_pix_cnt   <= '0;
        end else begin
            // NOTE: non-blocking throughout so every branch sees pre-edge state;
            // the pulse outputs default low here and are raised for one cycle below.
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        if (w_win_bad) begin
                            r_err <= 1'b1;
                        end else begin
                            r_x0      <= w_x0;
                            r_x1      <= w_x1;
                            r_y0      <= w_y0;
                            r_y1      <= w_y1;
                            r_pix_x   <= w_x0;
                            r_pix_y   <= w_y0;
                            r_sig     <= '0;
                            r_pix_cnt <= '0;
                            r_busy    <= 1'b1;
                            r_settle  <= LAT_LOAD;
                            r_state   <= S_SETTLE;
                        end
                    end
                end
                S_SETTLE: begin
                    if (abort) begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else if (r_settle == '0) begin
                        r_out_x     <= r_pix_x;
                        r_out_y     <= r_pix_y;
                        r_out_rgb   <= rgb_in;
                        r_out_valid <= 1'b1;
                        r_state     <= S_HOLD;
                    end else begin
                        r_settle <= r_settle - 1'b1;
                    end
                end
                S_HOLD: begin
                    // A beat accepted in the abort cycle still counts.
                    if (w_handshake) begin
                        r_sig       <= w_sig_next;
                        r_pix_cnt   <= w_cnt_next;
                        r_out_valid <= 1'b0;
                    end
                    if (abort) begin
                        r_out_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_state     <= S_IDLE;
                    end else if (w_handshake) begin
                        if (w_last) begin
                            r_state <= S_DONE;
                        end else begin
                            if (r_pix_x == r_x1) begin
                                r_pix_x <= r_x0;
                                r_pix_y <= r_pix_y + 1'b1;
                            end else begin
                                r_pix_x <= r_pix_x + 1'b1;
                            end
                            r_settle <= LAT_LOAD;
                            r_state  <= S_SETTLE;
                        end
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_done  <= ~abort;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign pix_x     = r_pix_x;
    assign pix_y     = r_pix_y;
    assign out_valid = r_out_valid;
    assign out_x     = r_out_x;
    assign out_y     = r_out_y;
    assign out_rgb   = r_out_rgb;
    assign busy      = r_busy;
    assign done      = r_done;
    assign err       = r_err;
    assign sig       = r_sig;
    assign pix_cnt   = r_pix_cnt;

endmodule
